// File: rtl/mod_seq_pkg.sv
// rtl/mod_seq_pkg.sv - shared types and default widths for the modulation sequencer
package mod_seq_pkg;

  localparam int MOD_SEQ_DEPTH = 8;
  localparam int MOD_SEQ_HP_W  = 16;
  localparam int MOD_SEQ_DUR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mod_seq_state_t;

  typedef struct packed {
    logic [MOD_SEQ_HP_W-1:0]  half_period;
    logic [MOD_SEQ_DUR_W-1:0] duration;
  } mod_seq_entry_t;

endpackage

// File: rtl/mod_seq_table.sv
// rtl/mod_seq_table.sv - sequence entry register file, one write port, one combinational read port
module mod_seq_table
  import mod_seq_pkg::*;
#(
  parameter int DEPTH = MOD_SEQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  mod_seq_entry_t           wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output mod_seq_entry_t           rd_data
);

  // No reset on the array so it maps onto distributed RAM; software rewrites it after reset.
  mod_seq_entry_t mem [DEPTH];

  // Write port; a same-cycle read of the same entry sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mod_sequencer.sv
// rtl/mod_sequencer.sv - plays a table of half-period steps into modulation; MOD_SEQ_LOOP_EN enables looping
module mod_sequencer
  import mod_seq_pkg::*;
#(
  parameter int DEPTH = MOD_SEQ_DEPTH,
  parameter int HP_W  = MOD_SEQ_HP_W,
  parameter int DUR_W = MOD_SEQ_DUR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [HP_W-1:0]          wr_half_period,
  input  logic [DUR_W-1:0]         wr_duration,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mod_out_fb,
  output logic [HP_W-1:0]          mod_half_period,
  output logic                     mod_set,
  output logic                     mod_enable,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DUR_W-1:0] DUR_ONE = 1;

  mod_seq_state_t state, state_next;

  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_q;
  logic [DUR_W-1:0] cnt;
  logic [HP_W-1:0]  hp_q;
  logic             fb_q;
  logic             en_q;
  logic             done_q;
  logic             fb_rise;
  logic             loop_eff;

  logic go;
  logic advance;
  logic wrap;
  logic finish;

  mod_seq_entry_t wr_entry;
  mod_seq_entry_t rd_entry;

  assign wr_entry.half_period = wr_half_period;
  assign wr_entry.duration    = wr_duration;

  mod_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry),
    .rd_addr (idx),
    .rd_data (rd_entry)
  );

`ifdef MOD_SEQ_LOOP_EN
  logic loop_q;

  // Loop mode is captured at start so host changes mid-sequence have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q <= 1'b0;
    end else if (go) begin
      loop_q <= loop;
    end
  end

  assign loop_eff = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_eff    = 1'b0;
`endif

  assign fb_rise = mod_out_fb & ~fb_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; stop overrides every other transition, including a same-cycle start.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    advance    = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          go         = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        if (fb_rise && (cnt == DUR_ONE)) begin
          if (idx != last_q) begin
            advance    = 1'b1;
            state_next = LOAD;
          end else if (loop_eff) begin
            wrap       = 1'b1;
            state_next = LOAD;
          end else begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (stop) begin
      state_next = IDLE;
      go         = 1'b0;
      advance    = 1'b0;
      wrap       = 1'b0;
      finish     = 1'b0;
    end
  end

  // Datapath: entry index, period down-counter, held half-period, enable and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      last_q <= '0;
      cnt    <= '0;
      hp_q   <= '0;
      fb_q   <= 1'b1;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fb_q   <= mod_out_fb;
      done_q <= finish;
      if (go) begin
        idx    <= '0;
        last_q <= last_idx;
      end else if (advance) begin
        idx <= idx + 1'b1;
      end else if (wrap) begin
        idx <= '0;
      end
      if (state == LOAD) begin
        cnt  <= (rd_entry.duration == '0) ? DUR_ONE : rd_entry.duration;
        hp_q <= rd_entry.half_period;
      end else if ((state == RUN) && fb_rise) begin
        cnt <= cnt - DUR_ONE;
      end
      if (state_next == IDLE) begin
        en_q <= 1'b0;
      end else if (state == LOAD) begin
        en_q <= 1'b1;
      end
    end
  end

  assign mod_half_period = (state == LOAD) ? rd_entry.half_period : hp_q;
  assign mod_set         = (state == LOAD);
  assign mod_enable      = en_q;
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign step_idx        = idx;

endmodule

// File: tb/tb_mod_sequencer.sv
// tb/tb_mod_sequencer.sv - directed self-checking bench for mod_sequencer (expectations follow MOD_SEQ_LOOP_EN)
module tb_mod_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_half_period = '0;
  logic [15:0]   wr_duration = '0;
  logic [AW-1:0] last_idx = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mod_out_fb = 1'b0;
  logic [15:0]   mod_half_period;
  logic          mod_set;
  logic          mod_enable;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  int n_checks = 0;
  int n_errors = 0;

  mod_sequencer #(.DEPTH(DEPTH), .HP_W(16), .DUR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_half_period (wr_half_period),
    .wr_duration    (wr_duration),
    .last_idx       (last_idx),
    .loop           (loop),
    .start          (start),
    .stop           (stop),
    .mod_out_fb     (mod_out_fb),
    .mod_half_period(mod_half_period),
    .mod_set        (mod_set),
    .mod_enable     (mod_enable),
    .busy           (busy),
    .done           (done),
    .step_idx       (step_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [15:0] hp, input logic [15:0] dur);
    wr_addr        = a;
    wr_half_period = hp;
    wr_duration    = dur;
    wr_en          = 1'b1;
    step();
    wr_en          = 1'b0;
  endtask

  task automatic fb_pulse();
    mod_out_fb = 1'b1;
    step();
    mod_out_fb = 1'b0;
    step();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_hp"},   mod_half_period, 0);
    check({tag, "_set"},  mod_set, 0);
    check({tag, "_en"},   mod_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_idx"},  step_idx, 0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("reset");

    // basic two-entry sequence
    write_entry(3'd0, 16'd3, 16'd2);
    write_entry(3'd1, 16'd6, 16'd1);
    last_idx = 3'd1;
    loop     = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("b_load0_set", mod_set, 1);
    check("b_load0_hp", mod_half_period, 3);
    check("b_load0_en", mod_enable, 0);
    check("b_load0_busy", busy, 1);
    step();
    check("b_run0_en", mod_enable, 1);
    check("b_run0_set", mod_set, 0);
    fb_pulse();
    check("b_run0_still", step_idx, 0);
    mod_out_fb = 1'b1;
    step();
    check("b_load1_set", mod_set, 1);
    check("b_load1_hp", mod_half_period, 6);
    check("b_load1_idx", step_idx, 1);
    check("b_load1_en", mod_enable, 1);
    mod_out_fb = 1'b0;
    step();
    mod_out_fb = 1'b1;
    step();
    check("b_done", done, 1);
    check("b_done_busy", busy, 0);
    check("b_done_en", mod_enable, 0);
    mod_out_fb = 1'b0;
    step();
    check("b_done_pulse", done, 0);
    check("b_hp_held", mod_half_period, 6);

    // loop request
    loop  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    loop  = 1'b0;
    step();
    fb_pulse();
    fb_pulse();
    mod_out_fb = 1'b1;
    step();
`ifdef MOD_SEQ_LOOP_EN
    check("l_wrap_idx", step_idx, 0);
    check("l_wrap_hp", mod_half_period, 3);
    check("l_wrap_set", mod_set, 1);
    check("l_wrap_done", done, 0);
`else
    check("l_noloop_done", done, 1);
    check("l_noloop_busy", busy, 0);
`endif
    mod_out_fb = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("l_stop_en", mod_enable, 0);
    check("l_stop_busy", busy, 0);
    check("l_stop_done", done, 0);

    // zero duration treated as one period
    write_entry(3'd0, 16'd5, 16'd0);
    last_idx = 3'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("z_load_hp", mod_half_period, 5);
    step();
    mod_out_fb = 1'b1;
    step();
    check("z_done", done, 1);
    mod_out_fb = 1'b0;
    step();

    // start and stop together
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_set", mod_set, 0);

    // start while busy is ignored
    write_entry(3'd0, 16'd3, 16'd2);
    last_idx = 3'd1;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("sb_set", mod_set, 0);
    check("sb_idx", step_idx, 0);
    check("sb_busy", busy, 1);

    // write to entry 1 in its own LOAD cycle uses the old value
    fb_pulse();
    mod_out_fb = 1'b1;
    step();
    mod_out_fb     = 1'b0;
    wr_addr        = 3'd1;
    wr_half_period = 16'd9;
    wr_duration    = 16'd1;
    wr_en          = 1'b1;
    check("rbw_load_hp", mod_half_period, 6);
    step();
    wr_en = 1'b0;
    check("rbw_held_hp", mod_half_period, 6);
    check("rbw_run_en", mod_enable, 1);

    // reset mid-RUN, then replay from entry 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("midrst");
    start = 1'b1;
    step();
    start = 1'b0;
    check("rp_hp", mod_half_period, 3);
    check("rp_idx", step_idx, 0);
    step();
    fb_pulse();
    mod_out_fb = 1'b1;
    step();
    check("rp_load1_hp", mod_half_period, 9);
    check("rp_load1_idx", step_idx, 1);
    mod_out_fb = 1'b0;
    step();
    mod_out_fb = 1'b1;
    step();
    check("rp_done", done, 1);
    mod_out_fb = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_sequencer.md
# mod_sequencer

Plays a programmed sequence of modulation half-periods into the `modulation` block, so the emitter array can run chirps or stepped-frequency patterns without host intervention. Holds a small table of {half_period, duration} entries and loads each one through `mod_half_period`/`mod_set`. It advances to the next entry after the programmed number of completed modulation periods, counted from `mod_out` feedback. Sits between the host register interface and `modulation`, owning `mod_enable`.

## Interface
- `DEPTH`, 8: number of table entries (power of two, ≥2)
- `HP_W`, 16: half-period width; matches `modulation` `mod_half_period`
- `DUR_W`, 16: duration width, in modulation periods
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `wr_en` in 1: table write strobe
- `wr_addr` in $clog2(DEPTH): table write index
- `wr_half_period` in HP_W: half-period to store
- `wr_duration` in DUR_W: duration to store
- `last_idx` in $clog2(DEPTH): index of the final entry; latched at start
- `loop` in 1: restart at entry 0 after `last_idx`; latched at start
- `start` in 1: begin sequence (single-cycle pulse)
- `stop` in 1: abort sequence (single-cycle pulse)
- `mod_out_fb` in 1: `mod_out` from `modulation`
- `mod_half_period` out HP_W: to `modulation`
- `mod_set` out 1: one-cycle load strobe to `modulation`
- `mod_enable` out 1: to `modulation`
- `busy` out 1: sequence active
- `done` out 1: one-cycle pulse on natural completion
- `step_idx` out $clog2(DEPTH): entry currently playing

## Operation
- Reset values: all outputs 0; state IDLE; edge-detect register = 1, matching the `modulation` idle level.
- FSM states:
  - IDLE: `mod_enable`=0, `busy`=0. `start` sets idx=0, latches `last_idx` and `loop`, and moves to LOAD.
  - LOAD (1 cycle): drives `mod_half_period`=table[idx] and `mod_set`=1. Loads the down-counter with max(duration,1); a stored duration of 0 is treated as 1. Then RUN.
  - RUN: `mod_enable`=1. Each rising edge of `mod_out_fb` (fb & ~fb_q) decrements the counter. On the edge that reaches 0:
    - if idx≠last_idx: idx+1, go to LOAD.
    - if idx=last_idx and latched loop=1: idx=0, go to LOAD.
    - otherwise: pulse `done`, go to IDLE.
- `mod_enable` stays 1 through inter-step LOAD cycles; it drops only on entry to IDLE.
- `mod_half_period` holds its last value in IDLE.
- `stop` in any state: IDLE next cycle, no `done` pulse. `stop` and `start` in the same cycle: stop wins.
- `start` while `busy` is ignored.
- Table writes are accepted in any state.
  - A write to an entry not yet loaded takes effect when that entry loads.
  - A write and a LOAD of the same entry in the same cycle: LOAD uses the old value (read-before-write).
- `last_idx` greater than DEPTH-1 cannot occur, because the widths match.
- `rst` mid-sequence: all outputs return to their reset values next cycle. Table contents after reset are undefined; software rewrites them.

## Timing
- `start` sampled at edge t; LOAD outputs visible in cycle t+1; `mod_enable`=1 from cycle t+2.
- Edge detection adds 1 cycle: a `mod_out_fb` rising edge at cycle k decrements at edge k+1.
- Final edge to next LOAD: 1 cycle. Final edge to `done`: 1 cycle, with `busy` and `mod_enable` low in the same cycle as `done`.
- Table write: 1-cycle latency, visible to a LOAD in the following cycle.

## Configuration
- `MOD_SEQ_LOOP_EN` defined: `loop` input honoured as described above.
- Not defined: the `loop` port remains but is ignored. The sequence always terminates with `done` after `last_idx`, and the latched loop register is not synthesized.

## Structure
- `mod_seq_pkg` contains:
  - `mod_seq_state_t` enum {IDLE, LOAD, RUN}
  - `mod_seq_entry_t` struct {half_period[HP_W], duration[DUR_W]}
  - default width constants
- Sub-module `mod_seq_table`: DEPTH×`mod_seq_entry_t` register file, 1 write port, 1 combinational read port, read-before-write. Distributed-RAM friendly.

## Test plan
- Basic sequence: table {3,2},{6,1}, `last_idx`=1, `start` -> LOAD with `mod_half_period`=3 and `mod_set` pulse; after 2 fb rising edges, LOAD with 6; after 1 more edge, `done`=1 for one cycle, `busy`=0, `mod_enable`=0.
- Loop (macro defined): same table, `loop`=1 -> after entry 1 completes, `step_idx`=0 and `mod_half_period`=3 again; `done` never asserts; `stop` -> `mod_enable`=0 next cycle, no `done`.
- Zero duration: entry {5,0}, `last_idx`=0 -> exactly one fb rising edge before `done`.
- Collisions: `start` and `stop` in the same cycle -> stays IDLE. `start` while busy -> no change to `step_idx` or `mod_set`. Write {9,1} to entry 1 in the same cycle entry 1 loads -> the old half-period is driven.
- Reset mid-RUN: `rst`=1 for 1 cycle -> all outputs 0 next cycle; a subsequent `start` replays from entry 0.
- Closed loop: bench instantiates `modulation` with `mod_out` fed back to `mod_out_fb`; two-entry sequence {3,1},{6,1} -> `mod_out` period visibly doubles after the first period; `done` asserts after the second period.
